// File: rtl/fighter_pkg.sv
// Shared fighter definitions: state codes, hit kinds and the direction decode
// also used by the AI player.
package fighter_pkg;

  localparam int unsigned ST_W = 4;
  typedef logic [ST_W-1:0] state_t;

  localparam state_t ST_IDLE  = 4'd0;
  localparam state_t ST_FWD   = 4'd1;
  localparam state_t ST_BACK  = 4'd2;
  localparam state_t ST_B_SU  = 4'd3;
  localparam state_t ST_B_ACT = 4'd4;
  localparam state_t ST_B_REC = 4'd5;
  localparam state_t ST_D_SU  = 4'd6;
  localparam state_t ST_D_ACT = 4'd7;
  localparam state_t ST_D_REC = 4'd8;
  localparam state_t ST_HSTUN = 4'd9;
  localparam state_t ST_BSTUN = 4'd10;

  localparam logic HIT_BASIC = 1'b0;
  localparam logic HIT_DIR   = 1'b1;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_FWD  = 2'd1,
    DIR_BACK = 2'd2
  } dir_e;

  // Pressing both buttons always means back (guard), regardless of side.
  function automatic dir_e dir_decode(input logic side, input logic left, input logic right);
    dir_e d;
    logic fwd_btn;
    logic back_btn;
    fwd_btn  = side ? left : right;
    back_btn = side ? right : left;
    d = DIR_NONE;
    if (left && right) d = DIR_BACK;
    else if (fwd_btn)  d = DIR_FWD;
    else if (back_btn) d = DIR_BACK;
    return d;
  endfunction

endpackage

// File: rtl/fighter_frame_timer.sv
// Frame-count timer for timed fighter states; expire is high while the count is zero.
module fighter_frame_timer #(
  parameter int unsigned TMR_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  input  logic             tick,
  output logic [TMR_W-1:0] value,
  output logic             expire
);

  logic [TMR_W-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (load)                         value_d = load_val;
    else if (tick && value_q != '0)   value_d = value_q - TMR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) value_q <= '0;
    else     value_q <= value_d;
  end

  assign value  = value_q;
  assign expire = (value_q == '0);

endmodule

// File: rtl/fighter_ctrl.sv
// Per-player fighter controller: movement, basic/directional attacks and hit/block
// stun, advanced once per frame_tick while run is high.
module fighter_ctrl
  import fighter_pkg::*;
#(
  parameter bit          SIDE     = 1'b0,
  parameter int unsigned POS_W    = 10,
  parameter int unsigned START_X  = 100,
  parameter int unsigned X_MIN    = 10,
  parameter int unsigned X_MAX    = 517,
  parameter int unsigned SPD_FWD  = 3,
  parameter int unsigned SPD_BACK = 2,
  parameter int unsigned MIN_GAP  = 30,
  parameter int unsigned B_SU     = 5,
  parameter int unsigned B_ACT    = 2,
  parameter int unsigned B_REC    = 16,
  parameter int unsigned D_SU     = 4,
  parameter int unsigned D_ACT    = 3,
  parameter int unsigned D_REC    = 15,
  parameter int unsigned HS_B     = 15,
  parameter int unsigned HS_D     = 14,
  parameter int unsigned BS_B     = 13,
  parameter int unsigned BS_D     = 12,
  parameter int unsigned BUF_FR   = 4,
  parameter int unsigned TMR_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_tick,
  input  logic             run,
  input  logic             left,
  input  logic             right,
  input  logic             attack,
  input  logic [POS_W-1:0] opp_posx,
  input  logic             hit_valid,
  input  logic             hit_kind,
  input  logic             block_ok,
  output logic             hit_ack,
  output logic             blocked,
  output logic [POS_W-1:0] posx,
  output logic [ST_W-1:0]  state,
  output logic             atk_active,
  output logic [TMR_W-1:0] frame_left
);

  localparam int unsigned PW = POS_W + 1;

  state_t           state_q, state_d;
  logic [POS_W-1:0] posx_q, posx_d;
  logic [TMR_W-1:0] buf_q, buf_d;
  logic             atk_prev_q, atk_prev_d;
  logic             hit_ack_q, hit_ack_d;
  logic             blocked_q, blocked_d;
  logic             atk_active_q, atk_active_d;

  logic             tick_c, atk_req_c, stun_c, ahead_c;
  logic             tmr_load_c, tmr_expire_c;
  logic [TMR_W-1:0] tmr_val_c, tmr_value_c;
  dir_e             dir_c;
  state_t           free_next_c;
  logic [PW-1:0]    mp_c, mo_c, dist_c, room_c, step_c, fwd_pos_c, back_pos_c;

  // Timer load value on entry: duration-1 for timed states, 0 for free states.
  function automatic logic [TMR_W-1:0] entry_val(input state_t st, input logic kind);
    int unsigned n;
    case (st)
      ST_B_SU:  n = B_SU;
      ST_B_ACT: n = B_ACT;
      ST_B_REC: n = B_REC;
      ST_D_SU:  n = D_SU;
      ST_D_ACT: n = D_ACT;
      ST_D_REC: n = D_REC;
      ST_HSTUN: n = (kind == HIT_DIR) ? HS_D : HS_B;
      ST_BSTUN: n = (kind == HIT_BASIC) ? BS_B : BS_D;
      default:  n = 1;
    endcase
    return TMR_W'(n - 1);
  endfunction

  function automatic state_t dir_state(input dir_e d);
    case (d)
      DIR_FWD:  return ST_FWD;
      DIR_BACK: return ST_BACK;
      default:  return ST_IDLE;
    endcase
  endfunction

  function automatic logic [PW-1:0] inc_clamp(input logic [PW-1:0] p, input logic [PW-1:0] s);
    logic [PW-1:0] q;
    q = p + s;
    return (q > PW'(X_MAX)) ? PW'(X_MAX) : q;
  endfunction

  function automatic logic [PW-1:0] dec_clamp(input logic [PW-1:0] p, input logic [PW-1:0] s);
    return (p < PW'(X_MIN) + s) ? PW'(X_MIN) : p - s;
  endfunction

  assign tick_c      = frame_tick & run;
  assign atk_req_c   = attack | (buf_q != '0);
  assign stun_c      = (state_q == ST_HSTUN) || (state_q == ST_BSTUN);
  assign dir_c       = dir_decode(SIDE, left, right);
  assign free_next_c = atk_req_c ? ST_B_SU : dir_state(dir_c);

  fighter_frame_timer #(.TMR_W(TMR_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load_c),
    .load_val (tmr_val_c),
    .tick     (tick_c),
    .value    (tmr_value_c),
    .expire   (tmr_expire_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      posx_q       <= POS_W'(START_X);
      buf_q        <= '0;
      atk_prev_q   <= 1'b0;
      hit_ack_q    <= 1'b0;
      blocked_q    <= 1'b0;
      atk_active_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      posx_q       <= posx_d;
      buf_q        <= buf_d;
      atk_prev_q   <= atk_prev_d;
      hit_ack_q    <= hit_ack_d;
      blocked_q    <= blocked_d;
      atk_active_q <= atk_active_d;
    end
  end

  // Next state, timer control and attack buffer.
  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    atk_prev_d = attack;
    tmr_load_c = 1'b0;
    tmr_val_c  = '0;
    if (!run) begin
      state_d    = ST_IDLE;
      buf_d      = '0;
      tmr_load_c = 1'b1;
    end else begin
      if (tick_c) begin
        if (hit_valid && !stun_c) begin
          state_d = (state_q == ST_BACK && block_ok) ? ST_BSTUN : ST_HSTUN;
        end else begin
          case (state_q)
            ST_IDLE:          state_d = atk_req_c ? ST_B_SU : dir_state(dir_c);
            ST_FWD, ST_BACK:  state_d = atk_req_c ? ST_D_SU : dir_state(dir_c);
            ST_B_SU:          if (tmr_expire_c) state_d = ST_B_ACT;
            ST_B_ACT:         if (tmr_expire_c) state_d = ST_B_REC;
            ST_D_SU:          if (tmr_expire_c) state_d = ST_D_ACT;
            ST_D_ACT:         if (tmr_expire_c) state_d = ST_D_REC;
            ST_B_REC, ST_D_REC, ST_HSTUN, ST_BSTUN:
                              if (tmr_expire_c) state_d = free_next_c;
            default:          state_d = ST_IDLE;
          endcase
        end
        if (state_d != state_q) begin
          tmr_load_c = 1'b1;
          tmr_val_c  = entry_val(state_d, hit_kind);
        end
        if (buf_q != '0) buf_d = buf_q - TMR_W'(1);
      end
      if (attack && !atk_prev_q) buf_d = TMR_W'(BUF_FR);
      if (state_d != state_q && (state_d == ST_B_SU || state_d == ST_D_SU)) buf_d = '0;
    end
  end

  // Registered outputs and clamped, gap-limited movement.
  always_comb begin
    hit_ack_d    = tick_c & hit_valid & ~stun_c;
    blocked_d    = hit_ack_d & (state_q == ST_BACK) & block_ok;
    atk_active_d = run & ((state_d == ST_B_ACT) || (state_d == ST_D_ACT));

    mp_c = PW'(posx_q);
    mo_c = PW'(opp_posx);
    if (SIDE == 1'b0) begin
      ahead_c = (mo_c >= mp_c);
      dist_c  = mo_c - mp_c;
    end else begin
      ahead_c = (mo_c <= mp_c);
      dist_c  = mp_c - mo_c;
    end
    room_c = (dist_c >= PW'(MIN_GAP)) ? dist_c - PW'(MIN_GAP) : '0;
    step_c = PW'(SPD_FWD);
    if (ahead_c && room_c < step_c) step_c = room_c;
    fwd_pos_c  = SIDE ? dec_clamp(mp_c, step_c) : inc_clamp(mp_c, step_c);
    back_pos_c = SIDE ? inc_clamp(mp_c, PW'(SPD_BACK)) : dec_clamp(mp_c, PW'(SPD_BACK));

    posx_d = posx_q;
    if (!run)                                    posx_d = POS_W'(START_X);
    else if (tick_c && state_d == ST_FWD)        posx_d = POS_W'(fwd_pos_c);
    else if (tick_c && state_d == ST_BACK)       posx_d = POS_W'(back_pos_c);
  end

  assign hit_ack    = hit_ack_q;
  assign blocked    = blocked_q;
  assign posx       = posx_q;
  assign state      = state_q;
  assign atk_active = atk_active_q;
  assign frame_left = tmr_value_c;

endmodule

// File: tb/tb_fighter_ctrl.sv
// Vector/scoreboard bench for fighter_ctrl: three instances cover SIDE=0, SIDE=1
// and BUF_FR=0, each with its own frame tick and buttons.
module tb_fighter_ctrl;

  localparam int NI = 3;
  localparam int IDLE = 0, FWD = 1, BACK = 2, BSU = 3, BACT = 4, BREC = 5;
  localparam int DSU = 6, DACT = 7, HST = 9, BST = 10;

  logic       clk = 1'b0;
  logic       rst, run;
  logic       ft[NI], lft[NI], rgt[NI], atk[NI], hv[NI], hk[NI], bo[NI];
  logic [9:0] opp[NI];
  logic       ack_o[NI], blk_o[NI], act_o[NI];
  logic [9:0] px_o[NI];
  logic [3:0] st_o[NI];
  logic [4:0] fl_o[NI];

  always #5 clk = ~clk;

  fighter_ctrl u0 (
    .clk(clk), .rst(rst), .frame_tick(ft[0]), .run(run), .left(lft[0]), .right(rgt[0]),
    .attack(atk[0]), .opp_posx(opp[0]), .hit_valid(hv[0]), .hit_kind(hk[0]), .block_ok(bo[0]),
    .hit_ack(ack_o[0]), .blocked(blk_o[0]), .posx(px_o[0]), .state(st_o[0]),
    .atk_active(act_o[0]), .frame_left(fl_o[0]));

  fighter_ctrl #(.SIDE(1'b1), .START_X(500)) u1 (
    .clk(clk), .rst(rst), .frame_tick(ft[1]), .run(run), .left(lft[1]), .right(rgt[1]),
    .attack(atk[1]), .opp_posx(opp[1]), .hit_valid(hv[1]), .hit_kind(hk[1]), .block_ok(bo[1]),
    .hit_ack(ack_o[1]), .blocked(blk_o[1]), .posx(px_o[1]), .state(st_o[1]),
    .atk_active(act_o[1]), .frame_left(fl_o[1]));

  fighter_ctrl #(.START_X(11), .BUF_FR(0)) u2 (
    .clk(clk), .rst(rst), .frame_tick(ft[2]), .run(run), .left(lft[2]), .right(rgt[2]),
    .attack(atk[2]), .opp_posx(opp[2]), .hit_valid(hv[2]), .hit_kind(hk[2]), .block_ok(bo[2]),
    .hit_ack(ack_o[2]), .blocked(blk_o[2]), .posx(px_o[2]), .state(st_o[2]),
    .atk_active(act_o[2]), .frame_left(fl_o[2]));

  // One frame of stimulus plus the outputs expected right after that frame's tick.
  // ap = attack pressed only in the cycle before the tick (an edge between frames).
  typedef struct {
    int inst;
    bit l, r, a, ap, hv, hk, bo;
    int opp, st, px, fl;
    bit ack, blk;
  } vec_t;

  vec_t vecs_a[$];
  vec_t vecs_b[$];
  vec_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic vec_t mv(int inst, int l, int r, int a, int ap, int op, int st, int px, int fl);
    vec_t v;
    v.inst = inst; v.l = (l != 0); v.r = (r != 0); v.a = (a != 0); v.ap = (ap != 0);
    v.hv = 1'b0; v.hk = 1'b0; v.bo = 1'b0;
    v.opp = op; v.st = st; v.px = px; v.fl = fl; v.ack = 1'b0; v.blk = 1'b0;
    return v;
  endfunction

  function automatic vec_t mh(int inst, int l, int kind, int bok, int op, int st, int px, int fl, int blk);
    vec_t v;
    v = mv(inst, l, 0, 0, 0, op, st, px, fl);
    v.hv = 1'b1; v.hk = (kind != 0); v.bo = (bok != 0); v.ack = 1'b1; v.blk = (blk != 0);
    return v;
  endfunction

  // Basic attack from a tick-0 press, with an attack edge two frames before recovery ends.
  task automatic add_attack(inout vec_t q[$], input int inst, input int px, input int op, input bit buffered);
    int st, fl;
    for (int i = 0; i < 24; i++) begin
      if (i <= 4)      begin st = BSU;  fl = 4 - i;  end
      else if (i <= 6) begin st = BACT; fl = 6 - i;  end
      else if (i < 23) begin st = BREC; fl = 22 - i; end
      else if (buffered) begin st = BSU; fl = 4; end
      else             begin st = IDLE; fl = 0;      end
      q.push_back(mv(inst, 0, 0, (i == 0) ? 1 : 0, (i == 21) ? 1 : 0, op, st, px, fl));
    end
    if (buffered) begin
      for (int i = 24; i <= 46; i++) begin
        if (i <= 27)      begin st = BSU;  fl = 27 - i; end
        else if (i <= 29) begin st = BACT; fl = 29 - i; end
        else if (i <= 45) begin st = BREC; fl = 45 - i; end
        else              begin st = IDLE; fl = 0;      end
        q.push_back(mv(inst, 0, 0, 0, 0, op, st, px, fl));
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic check_front(input int idx);
    vec_t e;
    int   i;
    e = exp_q.pop_front();
    i = e.inst;
    chk($sformatf("u%0d v%0d state", i, idx), int'(st_o[i]), e.st);
    chk($sformatf("u%0d v%0d posx", i, idx), int'(px_o[i]), e.px);
    chk($sformatf("u%0d v%0d frame_left", i, idx), int'(fl_o[i]), e.fl);
    chk($sformatf("u%0d v%0d hit_ack", i, idx), int'(ack_o[i]), int'(e.ack));
    chk($sformatf("u%0d v%0d blocked", i, idx), int'(blk_o[i]), int'(e.blk));
    chk($sformatf("u%0d v%0d atk_active", i, idx), int'(act_o[i]),
        (e.st == BACT || e.st == DACT) ? 1 : 0);
  endtask

  task automatic step(input vec_t v, input int idx);
    @(negedge clk);
    lft[v.inst] = v.l; rgt[v.inst] = v.r; atk[v.inst] = v.a | v.ap;
    hv[v.inst] = v.hv; hk[v.inst] = v.hk; bo[v.inst] = v.bo; opp[v.inst] = 10'(v.opp);
    @(negedge clk);
    atk[v.inst] = v.a;
    ft[v.inst]  = 1'b1;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    ft[v.inst] = 1'b0;
    check_front(idx);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    int   px;

    // u0: basic attack with buffered re-attack.
    add_attack(vecs_a, 0, 100, 200, 1'b1);
    // u0: walk toward opponent at 200, stopping at the 30 px gap.
    for (int k = 1; k <= 25; k++) begin
      px = (100 + 3 * k > 170) ? 170 : 100 + 3 * k;
      vecs_a.push_back(mv(0, 0, 1, 0, 0, 200, FWD, px, 0));
    end
    // u0: blocked directional hit, then unblocked one (with a held hit during stun).
    vecs_a.push_back(mv(0, 1, 0, 0, 0, 200, BACK, 168, 0));
    vecs_a.push_back(mh(0, 1, 1, 1, 200, BST, 168, 11, 1));
    for (int j = 0; j <= 10; j++) vecs_a.push_back(mv(0, 1, 0, 0, 0, 200, BST, 168, 10 - j));
    vecs_a.push_back(mv(0, 1, 0, 0, 0, 200, BACK, 166, 0));
    vecs_a.push_back(mh(0, 1, 1, 0, 200, HST, 166, 13, 0));
    for (int j = 0; j <= 12; j++) begin
      v = mv(0, 1, 0, 0, 0, 200, HST, 166, 12 - j);
      if (j == 3) begin v.hv = 1'b1; v.hk = 1'b1; end
      vecs_a.push_back(v);
    end
    vecs_a.push_back(mv(0, 1, 0, 0, 0, 200, BACK, 164, 0));
    // u0: directional attack from BACK into its active window.
    vecs_a.push_back(mv(0, 1, 0, 1, 0, 200, DSU, 164, 3));
    for (int j = 2; j >= 0; j--) vecs_a.push_back(mv(0, 0, 0, 0, 0, 200, DSU, 164, j));
    vecs_a.push_back(mv(0, 0, 0, 0, 0, 200, DACT, 164, 2));
    vecs_a.push_back(mv(0, 0, 0, 0, 0, 200, DACT, 164, 1));

    // u0 after run restore: hit beats a simultaneous attack press.
    v = mh(0, 0, 0, 1, 200, HST, 100, 14, 0);
    v.a = 1'b1;
    vecs_b.push_back(v);
    vecs_b.push_back(mv(0, 0, 0, 0, 0, 200, HST, 100, 13));
    // u1 (SIDE=1): right is back, clamps at X_MAX; left is forward; both is back.
    for (int k = 1; k <= 10; k++) begin
      px = (500 + 2 * k > 517) ? 517 : 500 + 2 * k;
      vecs_b.push_back(mv(1, 0, 1, 0, 0, 100, BACK, px, 0));
    end
    vecs_b.push_back(mv(1, 1, 0, 0, 0, 100, FWD, 514, 0));
    vecs_b.push_back(mv(1, 1, 1, 0, 0, 100, BACK, 516, 0));
    vecs_b.push_back(mv(1, 0, 0, 0, 0, 100, IDLE, 516, 0));
    // u2 (BUF_FR=0): X_MIN clamp, unbuffered attack, forward blocked inside the gap.
    vecs_b.push_back(mv(2, 1, 0, 0, 0, 300, BACK, 10, 0));
    vecs_b.push_back(mv(2, 1, 0, 0, 0, 300, BACK, 10, 0));
    vecs_b.push_back(mv(2, 0, 0, 0, 0, 300, IDLE, 10, 0));
    add_attack(vecs_b, 2, 10, 300, 1'b0);
    vecs_b.push_back(mv(2, 0, 1, 0, 0, 30, FWD, 10, 0));

    for (int i = 0; i < NI; i++) begin
      ft[i] = 1'b0; lft[i] = 1'b0; rgt[i] = 1'b0; atk[i] = 1'b0;
      hv[i] = 1'b0; hk[i] = 1'b0; bo[i] = 1'b0; opp[i] = 10'd300;
    end
    run = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset u0 posx", int'(px_o[0]), 100);
    chk("reset u1 posx", int'(px_o[1]), 500);
    chk("reset u2 posx", int'(px_o[2]), 11);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("reset u%0d state", i), int'(st_o[i]), IDLE);
      chk($sformatf("reset u%0d frame_left", i), int'(fl_o[i]), 0);
      chk($sformatf("reset u%0d hit_ack", i), int'(ack_o[i]), 0);
    end

    for (int n = 0; n < vecs_a.size(); n++) step(vecs_a[n], n);

    // Run drops mid D_ACT: back to the start condition on the next clock, no ack while held.
    @(negedge clk);
    run = 1'b0;
    @(posedge clk);
    #1;
    chk("rundrop state", int'(st_o[0]), IDLE);
    chk("rundrop posx", int'(px_o[0]), 100);
    chk("rundrop frame_left", int'(fl_o[0]), 0);
    chk("rundrop atk_active", int'(act_o[0]), 0);
    @(negedge clk);
    hv[0] = 1'b1;
    ft[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("rundrop hit_ack", int'(ack_o[0]), 0);
    chk("rundrop state held", int'(st_o[0]), IDLE);
    @(negedge clk);
    ft[0] = 1'b0;
    hv[0] = 1'b0;
    run   = 1'b1;

    for (int n = 0; n < vecs_b.size(); n++) step(vecs_b[n], 1000 + n);

    chk("scoreboard drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
